// File: rtl/spi_flash_loader.sv
// Boot-time dual-output fast-read SPI flash loader: streams bytes from the flash
// to the SDRAM write sequencer over a valid/ready byte interface.
module spi_flash_loader #(
    parameter logic [7:0] CMD    = 8'h3B,
    parameter logic [7:0] NDUMMY = 8'd8
) (
    input  logic        C25M,
    input  logic        RES,
    input  logic        Start,
    input  logic [23:0] FAddr,
    input  logic [15:0] Len,
    output logic        Busy,
    output logic        Done,
    output logic        nFCS,
    output logic        FCK,
    output logic        MOSIout,
    output logic        MOSIOE,
    input  logic        MOSIin,
    input  logic        MISO,
    output logic [7:0]  LDData,
    output logic [15:0] LDAddr,
    output logic        LDValid,
    input  logic        LDReady
);

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StDummy, StData, StDrain
    } stateT;

    stateT       state, stateNext;
    logic [7:0]  bitCnt, bitCntNext;
    logic [30:0] txShift, txShiftNext;
    logic [5:0]  rxShift, rxShiftNext;
    logic [15:0] byteCnt, byteCntNext;
    logic [15:0] lenReg, lenRegNext;
    logic        nFCSNext, FCKNext, MOSIoutNext, MOSIOENext;
    logic        busyNext, doneNext, ldValidNext;
    logic [7:0]  ldDataNext;
    logic [15:0] ldAddrNext;
    logic        accept;

    always_ff @(posedge C25M) begin
        if (RES) begin
            state   <= StIdle;
            bitCnt  <= '0;
            txShift <= '0;
            rxShift <= '0;
            byteCnt <= '0;
            lenReg  <= '0;
            nFCS    <= 1'b1;
            FCK     <= 1'b0;
            MOSIout <= 1'b0;
            MOSIOE  <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            LDValid <= 1'b0;
            LDData  <= '0;
            LDAddr  <= '0;
        end else begin
            state   <= stateNext;
            bitCnt  <= bitCntNext;
            txShift <= txShiftNext;
            rxShift <= rxShiftNext;
            byteCnt <= byteCntNext;
            lenReg  <= lenRegNext;
            nFCS    <= nFCSNext;
            FCK     <= FCKNext;
            MOSIout <= MOSIoutNext;
            MOSIOE  <= MOSIOENext;
            Busy    <= busyNext;
            Done    <= doneNext;
            LDValid <= ldValidNext;
            LDData  <= ldDataNext;
            LDAddr  <= ldAddrNext;
        end
    end

    // FCK doubles as the bit phase: low = phase 0, high = phase 1.
    always_comb begin
        stateNext   = state;
        bitCntNext  = bitCnt;
        txShiftNext = txShift;
        rxShiftNext = rxShift;
        byteCntNext = byteCnt;
        lenRegNext  = lenReg;
        nFCSNext    = nFCS;
        FCKNext     = FCK;
        MOSIoutNext = MOSIout;
        MOSIOENext  = MOSIOE;
        busyNext    = Busy;
        doneNext    = Done;
        ldDataNext  = LDData;
        ldAddrNext  = LDAddr;
        accept      = LDValid && LDReady;
        ldValidNext = accept ? 1'b0 : LDValid;

        case (state)
            StIdle: begin
                if (Start) begin
                    stateNext   = StCmd;
                    nFCSNext    = 1'b0;
                    FCKNext     = 1'b0;
                    MOSIOENext  = 1'b1;
                    MOSIoutNext = CMD[7];
                    txShiftNext = {CMD[6:0], FAddr};
                    bitCntNext  = '0;
                    byteCntNext = '0;
                    lenRegNext  = Len;
                    busyNext    = 1'b1;
                    doneNext    = 1'b0;
                end
            end
            StCmd, StAddr: begin
                FCKNext = ~FCK;
                if (FCK) begin
                    bitCntNext  = bitCnt + 8'd1;
                    MOSIoutNext = txShift[30];
                    txShiftNext = {txShift[29:0], 1'b0};
                    if (state == StCmd && bitCnt == 8'd7) begin
                        stateNext  = StAddr;
                        bitCntNext = '0;
                    end else if (state == StAddr && bitCnt == 8'd23) begin
                        stateNext   = StDummy;
                        bitCntNext  = '0;
                        MOSIOENext  = 1'b0;
                        MOSIoutNext = 1'b0;
                    end
                end
            end
            StDummy: begin
                FCKNext = ~FCK;
                if (FCK) begin
                    bitCntNext = bitCnt + 8'd1;
                    if (bitCnt == NDUMMY - 8'd1) begin
                        stateNext  = StData;
                        bitCntNext = '0;
                    end
                end
            end
            StData: begin
                if (!FCK) begin
                    // Stall at the start of a byte while the holding register is still full.
                    if (!(bitCnt[1:0] == 2'd0 && LDValid && !LDReady))
                        FCKNext = 1'b1;
                end else begin
                    FCKNext     = 1'b0;
                    bitCntNext  = bitCnt + 8'd1;
                    rxShiftNext = {rxShift[3:0], MISO, MOSIin};
                    if (bitCnt[1:0] == 2'd3) begin
                        ldDataNext  = {rxShift, MISO, MOSIin};
                        ldAddrNext  = byteCnt;
                        byteCntNext = byteCnt + 16'd1;
                        ldValidNext = 1'b1;
                        if (byteCnt + 16'd1 == lenReg) begin
                            stateNext  = StDrain;
                            nFCSNext   = 1'b1;
                            MOSIOENext = 1'b0;
                        end
                    end
                end
            end
            StDrain: begin
                if (accept) begin
                    stateNext = StIdle;
                    busyNext  = 1'b0;
                    doneNext  = 1'b1;
                end
            end
            default: stateNext = StIdle;
        endcase
    end

endmodule

// File: tb/tb_spi_flash_loader.sv
// Bench for spi_flash_loader: behavioural dual-output flash, byte scoreboard and
// cycle-position checks relative to the accepted Start edge.
module tb_spi_flash_loader;

    logic        C25M = 1'b0;
    logic        RES = 1'b1;
    logic        Start = 1'b0;
    logic [23:0] FAddr = '0;
    logic [15:0] Len = '0;
    logic        Busy, Done, nFCS, FCK, MOSIout, MOSIOE;
    logic        MOSIin = 1'b0;
    logic        MISO = 1'b0;
    logic [7:0]  LDData;
    logic [15:0] LDAddr;
    logic        LDValid;
    logic        LDReady = 1'b1;

    spi_flash_loader #(.CMD(8'h3B), .NDUMMY(8'd8)) dut (
        .C25M(C25M), .RES(RES), .Start(Start), .FAddr(FAddr), .Len(Len),
        .Busy(Busy), .Done(Done), .nFCS(nFCS), .FCK(FCK),
        .MOSIout(MOSIout), .MOSIOE(MOSIOE), .MOSIin(MOSIin), .MISO(MISO),
        .LDData(LDData), .LDAddr(LDAddr), .LDValid(LDValid), .LDReady(LDReady)
    );

    always #20 C25M = ~C25M;

    int nChecks = 0;
    int nFail = 0;

    int          cyc = 0, t0 = 0, rel = 0, r = 0;
    logic [31:0] mosiWord = '0;
    int          loadCyc[$];
    int          nfcsRise = -1, oeFall = -1, doneRise = -1, stallViol = 0;
    int          stallFrom = 0, stallLen = 0;
    logic        pValid = 1'b0, pNfcs = 1'b1, pOe = 1'b0, pDone = 1'b0;
    logic [7:0]  pData = '0;
    logic [15:0] pAddr = '0;
    logic [23:0] sbq[$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] flashByte(input logic [23:0] a);
        if (a == 24'h002000) return 8'hA5;
        if (a == 24'h002001) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ {a[3:0], a[7:4]} ^ 8'h96;
    endfunction

    // One clock: acceptance of the edge just passed, flash model, event capture.
    task automatic tick();
        logic [7:0]  fb;
        logic [7:0]  sh;
        logic [23:0] e;
        int          p;
        @(negedge C25M);
        cyc++;
        if (pValid && LDReady && !RES) begin
            if (sbq.size() == 0) begin
                checkVal("sb_unexpected", {8'h0, pAddr, pData}, 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                checkVal("sb_byte", {8'h0, pAddr, pData}, {8'h0, e});
            end
        end
        if (!nFCS && FCK && pValid && !LDReady) stallViol++;
        if (pNfcs && !nFCS) begin
            t0 = cyc; r = 0; mosiWord = '0;
            loadCyc.delete();
            nfcsRise = -1; oeFall = -1; doneRise = -1;
        end
        rel = cyc - t0;
        if (!nFCS && FCK) begin
            if (r < 32) begin
                mosiWord = {mosiWord[30:0], MOSIout};
            end else if (r >= 40) begin
                p  = r - 40;
                fb = flashByte(mosiWord[23:0] + 24'(p / 4));
                sh = fb >> (6 - 2 * (p % 4));
                MISO   = sh[1];
                MOSIin = sh[0];
            end
            r++;
        end
        if (LDValid && !pValid) loadCyc.push_back(rel);
        if (nFCS && !pNfcs)     nfcsRise = rel;
        if (!MOSIOE && pOe)     oeFall = rel;
        if (Done && !pDone)     doneRise = rel;
        pValid = LDValid; pNfcs = nFCS; pOe = MOSIOE; pDone = Done;
        pData = LDData; pAddr = LDAddr;
        LDReady = !(rel >= stallFrom && rel < stallFrom + stallLen);
    endtask

    task automatic startLoad(input logic [23:0] a, input logic [15:0] n, input int nPush);
        FAddr = a; Len = n; Start = 1'b1;
        for (int i = 0; i < nPush; i++) sbq.push_back({16'(i), flashByte(a + 24'(i))});
        tick();
        Start = 1'b0;
        FAddr = 24'($urandom);
        Len   = 16'($urandom);
    endtask

    task automatic waitDone(input int budget);
        int k = 0;
        while (!Done && k < budget) begin tick(); k++; end
        checkVal("done_reached", {31'h0, Done}, 32'h1);
    endtask

    task automatic waitDrained(input int budget);
        int k = 0;
        while (sbq.size() != 0 && k < budget) begin tick(); k++; end
        checkVal("drained", sbq.size(), 0);
    endtask

    initial begin
        repeat (3) tick();
        checkVal("rst_ctrl", {nFCS, FCK, MOSIout, MOSIOE, LDValid, Busy, Done}, 7'b1000000);
        checkVal("rst_lddata", LDData, 0);
        checkVal("rst_ldaddr", LDAddr, 0);
        RES = 1'b0;
        tick();

        // Basic two-byte load with an ignored Start pulse at cycle 40
        startLoad(24'h002000, 16'd2, 2);
        checkVal("c0_ctrl", {nFCS, FCK, MOSIout, MOSIOE, Busy}, 5'b00011);
        while (rel < 40) tick();
        FAddr = 24'hFFFFFF; Len = 16'd7; Start = 1'b1;
        tick();
        Start = 1'b0;
        waitDone(300);
        checkVal("t1_mosi", mosiWord, 32'h3B002000);
        checkVal("t1_oe_fall", oeFall, 64);
        checkVal("t1_nloads", loadCyc.size(), 2);
        checkVal("t1_load0", loadCyc[0], 88);
        checkVal("t1_load1", loadCyc[1], 96);
        checkVal("t1_nfcs_rise", nfcsRise, 96);
        checkVal("t1_done_rise", doneRise, 97);
        checkVal("t1_busy", {31'h0, Busy}, 0);
        checkVal("t1_sb_left", sbq.size(), 0);

        // Backpressure: consumer not ready for 20 cycles after the first byte
        stallViol = 0;
        startLoad(24'h002000, 16'd2, 2);
        checkVal("t2_done_clr", {31'h0, Done}, 0);
        stallFrom = 88; stallLen = 20;
        waitDone(300);
        stallLen = 0;
        checkVal("t2_load0", loadCyc[0], 88);
        checkVal("t2_load1", loadCyc[1], 116);
        checkVal("t2_nfcs_rise", nfcsRise, 116);
        checkVal("t2_done_rise", doneRise, 117);
        checkVal("t2_stall_fck", stallViol, 0);
        checkVal("t2_sb_left", sbq.size(), 0);

        RES = 1'b1;
        tick();
        RES = 1'b0;
        checkVal("rst_done_idle", {31'h0, Done}, 0);
        tick();

        // Reset held three cycles in the middle of the command
        startLoad(24'h002000, 16'd2, 2);
        while (rel < 6) tick();
        RES = 1'b1;
        tick();
        checkVal("t3_rst_ctrl", {nFCS, FCK, MOSIOE, LDValid, Busy, Done}, 6'b100000);
        tick(); tick();
        RES = 1'b0;
        sbq.delete();
        tick();
        checkVal("t3_rst_hold", {nFCS, Busy}, 2'b10);

        // Reset during the data phase, then a clean restart
        startLoad(24'h002000, 16'd2, 2);
        while (rel < 92) tick();
        RES = 1'b1;
        tick();
        RES = 1'b0;
        checkVal("t4_rst_ctrl", {nFCS, FCK, MOSIOE, LDValid, Busy}, 5'b10000);
        checkVal("t4_sb_pending", sbq.size(), 1);
        sbq.delete();
        tick();
        startLoad(24'h001000, 16'd3, 3);
        waitDone(400);
        checkVal("t4_mosi", mosiWord, 32'h3B001000);
        checkVal("t4_load0", loadCyc[0], 88);
        checkVal("t4_nfcs_rise", nfcsRise, 104);
        checkVal("t4_sb_left", sbq.size(), 0);

        // Single-byte load
        startLoad(24'h0ABCDE, 16'd1, 1);
        waitDone(300);
        checkVal("t5_nloads", loadCyc.size(), 1);
        checkVal("t5_nfcs_rise", nfcsRise, 88);
        checkVal("t5_done_rise", doneRise, 89);

        // Len=0 means 65536: past 300 bytes the load must still be running
        startLoad(24'h7FFF00, 16'd0, 300);
        waitDrained(4000);
        checkVal("t6_still_busy", {nFCS, Busy}, 2'b01);
        RES = 1'b1;
        tick();
        RES = 1'b0;
        sbq.delete();
        tick();
        checkVal("t6_rst_ctrl", {nFCS, Busy, LDValid}, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/spi_flash_loader.md
# spi_flash_loader

Boot-time SPI flash reader that sits directly upstream of the SDRAM write sequencer. It issues a dual-output fast-read command to the serial flash, deserializes 2 bits per SPI clock, and presents one byte at a time with a byte index on a valid/ready interface. The SDRAM stage consumes that interface and writes each byte into the ROM/driver bank.

## Interface
Parameters:
- CMD, 8'h3B: flash read opcode, shifted MSB first.
- NDUMMY, 8: dummy SPI clocks between address and data.

Ports:
- C25M  in  1  system clock, 25 MHz; all logic is on the rising edge.
- RES  in  1  reset, synchronous, active-high.
- Start  in  1  one-cycle load request; accepted only in IDLE.
- FAddr  in  24  flash start address; latched on accepted Start.
- Len  in  16  byte count; latched on accepted Start; 0 means 65536.
- Busy  out  1  high from accepted Start until the last byte is accepted.
- Done  out  1  high in IDLE after a completed load; cleared by Start or RES.
- nFCS  out  1  flash chip select, active low.
- FCK  out  1  SPI clock, mode 0 (idle low).
- MOSIout  out  1  serial data to flash (IO0).
- MOSIOE  out  1  IO0 output enable.
- MOSIin  in  1  IO0 as input during data phase (data bit 0 of each pair).
- MISO  in  1  IO1 (data bit 1 of each pair).
- LDData  out  8  byte to SDRAM stage.
- LDAddr  out  16  byte index relative to FAddr, starting at 0.
- LDValid  out  1  LDData/LDAddr valid.
- LDReady  in  1  consumer accepts the byte on a cycle where LDValid && LDReady.

## Operation
- Reset values: nFCS=1, FCK=0, MOSIout=0, MOSIOE=0, LDValid=0, LDData=0, LDAddr=0, Busy=0, Done=0, state=IDLE.
- States: IDLE -> CMD (8 bits) -> ADDR (24 bits) -> DUMMY (NDUMMY clocks) -> DATA -> DRAIN -> IDLE.
- Each SPI bit spans 2 C25M cycles:
  - Phase 0: FCK=0; MOSIout updates here.
  - Phase 1: FCK=1.
- CMD/ADDR: MOSIOE=1. Bits go out MSB first: CMD, then FAddr[23:0].
- DUMMY: MOSIOE=0 on entry, MOSIout=0, FCK keeps toggling.
- DATA: 4 bit-pairs per byte. At the edge ending phase 1, Shift <= {Shift[5:0], MISO, MOSIin}.
- At the 4th pair:
  - LDData <= {Shift[5:0], MISO, MOSIin}.
  - LDAddr <= byte counter, then the counter increments (16-bit, wraps).
  - LDValid <= 1.
- Backpressure: in DATA phase 0 of pair 0, if LDValid && ~LDReady, hold FCK low (stall). Resume on the first cycle the condition is false. The holding register therefore never overruns.
- LDValid clears on LDValid && LDReady. A load and a clear never coincide, because a load cannot happen while LDValid is high.
- Last byte (counter reaches Len; Len=0 means after 65536 bytes): on the edge that loads it, nFCS<=1, FCK<=0, MOSIOE<=0, state<=DRAIN.
- DRAIN -> IDLE on acceptance of that byte; on that edge Busy<=0 and Done<=1.
- Start outside IDLE is ignored. Start in IDLE clears Done.
- RES mid-operation: all outputs return to reset values on the next edge. nFCS deasserts immediately and any pending byte is discarded.

## Timing
- Accepted Start edge = cycle 0: nFCS=0, MOSIOE=1, MOSIout=CMD[7], FCK=0.
- Bit k phase 0 is at cycle 2k and phase 1 at cycle 2k+1.
  - CMD: cycles 0-15.
  - ADDR: cycles 16-63.
  - DUMMY: cycles 64-(63+2*NDUMMY).
- Data pair p of byte 0 is sampled at cycle 64+2*NDUMMY+2p+2. First LDValid is at cycle 88 with defaults.
- With no stalls, each subsequent byte arrives 8 cycles later, giving 1 byte per 8 cycles.
- Each stall cycle delays all later events by exactly one cycle.
- Last byte (index n = Len-1, or 65535 when Len=0, since LDAddr is the 0-based index) loads at cycle 88+8n; nFCS rises on that same edge.

## Test plan
- RES high 3 cycles, mid-CMD -> nFCS=1, FCK=0, MOSIOE=0, LDValid=0, Busy=0, Done=0 on the edge after RES is sampled.
- Start, FAddr=24'h002000, Len=2, LDReady=1, flash model returns A5,3C:
  - MOSIout sequence 3B,00,20,00.
  - MOSIOE falls at cycle 64.
  - LDValid at cycle 88 with A5/addr 0, and at cycle 96 with 3C/addr 1.
  - nFCS high at cycle 96; Done=1 at cycle 97.
- Same run, but LDReady=0 for 20 cycles after the first LDValid -> FCK held low during the stall, no byte lost, second byte at cycle 116.
- Start pulsed again at cycle 40 of a load -> ignored: FAddr/Len unchanged, MOSIout stream unchanged.
- RES asserted at cycle 92 during DATA, then a fresh Start -> clean restart: CMD 3B re-sent, LDAddr restarts at 0.
- Len=0, LDReady=1 -> 65536 bytes; final LDAddr=16'hFFFF; Done after its acceptance.
